spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target_pkg.sv | 18 +
 rtl/spi_target_sync.sv | 45 ++++
 rtl/spi_target.sv | 165 ++++++++++++++++
 tb/tb_spi_target.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_pkg
// Brief    : Shared state encoding and constants for the SPI target.
// Revision : 1.0
// ============================================================================
package spi_target_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [7:0] c_idle_fill  = 8'hFF;
  localparam int         c_sync_depth = 2;

endpackage
`default_nettype wire

// File: rtl/spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_sync
// Brief    : Two-flop pin synchronizer with rise/fall detection.
// Revision : 1.0
// ============================================================================
module spi_target_sync
  import spi_target_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [c_sync_depth-1:0] r_sync;
  logic                    r_hist;
  logic [c_sync_depth:0]   r_fill;
  logic                    w_level;
  logic                    w_primed;

  // Edges are masked until every stage holds a real pin sample, so a pin that
  // already sits at its active level when reset releases is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {c_sync_depth{RESET_VAL}};
      r_hist <= RESET_VAL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[c_sync_depth-2:0], pin};
      r_hist <= r_sync[c_sync_depth-1];
      r_fill <= {r_fill[c_sync_depth-1:0], 1'b1};
    end
  end

  assign w_level  = r_sync[c_sync_depth-1];
  assign w_primed = r_fill[c_sync_depth];
  assign rise     = w_primed &  w_level & ~r_hist;
  assign fall     = w_primed & ~w_level &  r_hist;

endmodule
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target with single-byte tx buffer and rx holding reg.
// Revision : 1.0
// ============================================================================
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [7:0] IDLE_FILL = c_idle_fill
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       overrun,
  output logic       underrun,
  input  logic       flags_clr,
  output logic       busy
);

  logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;

  spi_target_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_cs_n),
    .rise (w_cs_rise),
    .fall (w_cs_fall)
  );

  spi_target_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .pin  (spi_sck),
    .rise (w_sck_rise),
    .fall (w_sck_fall)
  );

  logic [c_sync_depth-1:0] r_mosi_sync;
  logic                    w_mosi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[c_sync_depth-2:0], spi_mosi};
  end

  assign w_mosi = r_mosi_sync[c_sync_depth-1];

  state_t r_state, w_state_nxt;
  logic   w_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        w_busy = 1'b1;
        if (w_cs_rise) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift_in;
  logic [7:0] r_shift_out;
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_overrun;
  logic       r_underrun;

  logic       w_sck_rise_act, w_sck_fall_act, w_start, w_reload, w_byte_done;
  logic [7:0] w_rx_byte;

  // SCK edges coinciding with CS release belong to no byte and are dropped.
  assign w_sck_rise_act = (r_state == ST_ACTIVE) & ~w_cs_rise & w_sck_rise;
  assign w_sck_fall_act = (r_state == ST_ACTIVE) & ~w_cs_rise & w_sck_fall;
  assign w_start        = (r_state == ST_IDLE) & w_cs_fall;
  assign w_reload       = w_start | (w_sck_fall_act & (r_bit_cnt == 3'd0));
  assign w_byte_done    = w_sck_rise_act & (r_bit_cnt == 3'd7);
  assign w_rx_byte      = {r_shift_in, w_mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
    end else begin
      if (w_start)             r_bit_cnt <= '0;
      else if (w_sck_rise_act) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_sck_rise_act) r_shift_in <= w_rx_byte[6:0];

      if (w_reload)            r_shift_out <= r_tx_full ? r_tx_buf : IDLE_FILL;
      else if (w_sck_fall_act) r_shift_out <= {r_shift_out[6:0], 1'b0};
    end
  end

  // A host write landing on the same cycle as a buffer copy wins: the copy
  // takes the old byte and the new one stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (tx_load) begin
        r_tx_buf  <= tx_data;
        r_tx_full <= 1'b1;
      end else if (w_reload && r_tx_full) begin
        r_tx_full <= 1'b0;
      end

      if (w_reload && !r_tx_full) r_underrun <= 1'b1;
      else if (flags_clr)         r_underrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_data  <= w_rx_byte;
        r_rx_valid <= 1'b1;
      end else if (rx_read) begin
        r_rx_valid <= 1'b0;
      end

      if (w_byte_done && r_rx_valid && !rx_read) r_overrun <= 1'b1;
      else if (flags_clr)                        r_overrun <= 1'b0;
    end
  end

  assign busy        = w_busy;
  assign spi_miso_oe = w_busy;
  assign spi_miso    = w_busy & r_shift_out[7];
  assign tx_full     = r_tx_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign overrun     = r_overrun;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Brief    : Randomized SPI master stimulus with a queue-based rx scoreboard.
// Revision : 1.0
// ============================================================================
module tb_spi_target;

  localparam int SH = 6;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs_n, spi_sck, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_load, tx_full;
  logic [7:0] rx_data;
  logic       rx_valid, rx_read;
  logic       overrun, underrun, flags_clr, busy;

  always #5 clk = ~clk;

  spi_target #(.IDLE_FILL(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_full     (tx_full),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_read     (rx_read),
    .overrun     (overrun),
    .underrun    (underrun),
    .flags_clr   (flags_clr),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] exp_rx_q[$];
  logic [7:0] m_tx_buf;
  logic       m_tx_full, m_rx_valid, m_overrun, m_underrun;
  logic [7:0] last_byte;
  logic [7:0] s_data[4];
  int         s_rmode[4];  // 0: no read, 1: read on completion, 2: read after byte

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_load();
    if (m_tx_full) begin
      m_tx_full = 1'b0;
      return m_tx_buf;
    end
    m_underrun = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void model_complete(input logic [7:0] b, input logic read_now);
    if (m_rx_valid && !read_now) m_overrun = 1'b1;
    m_rx_valid = 1'b1;
    exp_rx_q.push_back(b);
    last_byte = b;
  endfunction

  function automatic void model_reset();
    m_tx_buf = '0; m_tx_full = 0; m_rx_valid = 0; m_overrun = 0; m_underrun = 0;
  endfunction

  task automatic do_tx_load(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    m_tx_buf = d; m_tx_full = 1'b1;
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    m_rx_valid = 1'b0;
  endtask

  task automatic do_clr();
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    m_overrun = 1'b0; m_underrun = 1'b0;
  endtask

  task automatic check_flags();
    check1("busy", busy, 1'b0);
    check1("miso_oe", spi_miso_oe, 1'b0);
    check1("tx_full", tx_full, m_tx_full);
    check1("rx_valid", rx_valid, m_rx_valid);
    check1("overrun", overrun, m_overrun);
    check1("underrun", underrun, m_underrun);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] exp_miso, input int rmode);
    logic [7:0] got;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      repeat (SH) @(negedge clk);
      got[i] = spi_miso;
      spi_sck = 1'b1;
      if (i == 0) begin
        // Completion lands on the 3rd posedge after the SCK rise.
        @(negedge clk);
        model_complete(b, rmode == 1);
        @(negedge clk);
        if (rmode == 1) rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        repeat (SH - 3) @(negedge clk);
      end else begin
        repeat (SH) @(negedge clk);
      end
      spi_sck = 1'b0;
    end
    check8("miso_byte", got, exp_miso);
  endtask

  task automatic session(input int n);
    logic [7:0] em;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    em = model_load();
    for (int k = 0; k < n; k++) begin
      send_byte(s_data[k], em, s_rmode[k]);
      em = model_load();
      repeat (SH) @(negedge clk);
      if (s_rmode[k] == 2) do_read();
    end
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic partial(input logic [7:0] b, input int nbits);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    void'(model_load());
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (SH) @(negedge clk);
      spi_sck = 1'b1;
      repeat (SH) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (SH) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_all_zero();
    check1("rst_miso", spi_miso, 1'b0);
    check1("rst_miso_oe", spi_miso_oe, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tx_full", tx_full, 1'b0);
    check1("rst_rx_valid", rx_valid, 1'b0);
    check8("rst_rx_data", rx_data, 8'h00);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_underrun", underrun, 1'b0);
  endtask

  // Scoreboard monitor: a new rx byte is a rising rx_valid or a data change while valid.
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst && rx_valid && (!pv || rx_data !== pd)) begin
        if (exp_rx_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_unexpected: got %02h, expected no byte", rx_data);
        end else begin
          check8("rx_data", rx_data, exp_rx_q.pop_front());
        end
      end
      pv = rx_valid; pd = rx_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         n;
    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    tx_data = '0; tx_load = 1'b0; rx_read = 1'b0; flags_clr = 1'b0;
    model_reset();
    last_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero();
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loaded byte goes out while 0xA5 comes in.
    do_tx_load(8'h3C);
    s_data[0] = 8'hA5; s_rmode[0] = 0;
    session(1);
    check_flags();
    do_read(); do_clr();

    // Two bytes without reading.
    s_data[0] = 8'h12; s_rmode[0] = 0;
    s_data[1] = 8'h34; s_rmode[1] = 0;
    session(2);
    check_flags();
    check8("rx_hold", rx_data, 8'h34);
    do_read(); do_clr();

    // No tx byte: idle fill and underrun, then clear.
    s_data[0] = 8'h5C; s_rmode[0] = 0;
    session(1);
    check_flags();
    do_clr();
    check_flags();
    do_read();

    // Aborted partial byte followed by a full one.
    partial(8'hC3, 5);
    check_flags();
    s_data[0] = 8'h81; s_rmode[0] = 0;
    session(1);
    check_flags();
    do_read(); do_clr();

    // Read strobe coincident with completion.
    s_data[0] = 8'h11; s_rmode[0] = 0;
    s_data[1] = 8'h22; s_rmode[1] = 1;
    session(2);
    check_flags();
    do_read(); do_clr();

    // SCK activity with CS high is ignored.
    for (int i = 0; i < 10; i++) begin
      spi_sck = ~spi_sck;
      repeat (4) @(negedge clk);
    end
    spi_sck = 1'b0;
    repeat (4) @(negedge clk);
    check_flags();

    // Reset in the middle of a byte.
    s_data[0] = 8'h3E; s_rmode[0] = 0;
    session(1);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    void'(model_load());
    do_tx_load(8'h77);
    for (int i = 0; i < 3; i++) begin
      spi_mosi = 1'b1;
      repeat (SH) @(negedge clk);
      spi_sck = 1'b1;
      repeat (SH) @(negedge clk);
      spi_sck = 1'b0;
    end
    check8("rx_pending_pre_rst", 8'(exp_rx_q.size()), 8'd0);
    #2 rst = 1'b1;
    #1 check_all_zero();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check1("idle_after_rst_cs_low", busy, 1'b0);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    s_data[0] = 8'h5A; s_rmode[0] = 0;
    session(1);
    check_flags();
    do_read(); do_clr();

    // Randomized sessions against the model.
    for (int s = 0; s < 20; s++) begin
      if ($urandom_range(0, 1) == 1) do_tx_load(8'($urandom));
      if ($urandom_range(0, 3) == 0) do_tx_load(8'($urandom));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        do b = 8'($urandom); while (b == last_byte);
        s_data[k] = b;
        last_byte = b;
        s_rmode[k] = $urandom_range(0, 2);
      end
      session(n);
      check_flags();
      if ($urandom_range(0, 1) == 1) do_read();
      if ($urandom_range(0, 3) == 0) do_clr();
    end

    repeat (4) @(negedge clk);
    check8("rx_pending_end", 8'(exp_rx_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
